tdc_phase_error_decoder: RTL and testbench

//  Consumes one PFD/TDC measurement per reference edge and turns it into a signed phase-error word.

---
 rtl/tdc_pkg.sv | 33 +++
 rtl/tdc_phase_error_decoder_if.sv | 37 +++
 rtl/tdc_therm_popcount.sv | 27 ++
 rtl/tdc_phase_error_decoder.sv | 258 +++++++++++++++++++++++++
 tb/tb_tdc_phase_error_decoder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// ---------------------------------------------------------------------------
// tdc_pkg
//   Shared definitions for the TDC phase-error decoder:
//     - tdc_state_e : decoder FSM states (IDLE, CAPT, CALC, OUT)
//     - FINE_STEPS  : TDC stages per DCO period (width of the thermometer)
//     - CNT_W_DEF / ERR_W_DEF : default coarse-count and phase-error widths
//     - err_sat_max / err_sat_min : symmetric saturation limits for a
//       two's-complement phase-error word of a given width
// ---------------------------------------------------------------------------
package tdc_pkg;

    localparam int FINE_STEPS = 8;
    localparam int CNT_W_DEF  = 5;
    localparam int ERR_W_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } tdc_state_e;

    // Largest magnitude emitted for an err_w-bit word. The most negative
    // code is never used so that +limit and -limit are symmetric.
    function automatic int err_sat_max(input int err_w);
        return (1 << (err_w - 1)) - 1;
    endfunction

    function automatic int err_sat_min(input int err_w);
        return -((1 << (err_w - 1)) - 1);
    endfunction

endpackage

// File: rtl/tdc_phase_error_decoder_if.sv
// ---------------------------------------------------------------------------
// tdc_phase_error_decoder_if
//   Phase-error delivery channel from the decoder to the loop filter.
//   Signals:
//     phase_err  signed phase error, LSB = one TDC stage
//     err_valid  phase_err holds a word
//     err_ready  loop filter can take the word
//   Handshake: a word transfers on every rising ref_clk edge where
//   err_valid && err_ready. Once err_valid is high, phase_err stays stable
//   and err_valid stays high until that transfer; the only exception is the
//   block enable going low, which withdraws the word. err_ready may change
//   freely and never depends combinationally on err_valid in the decoder.
//   Modports:
//     master  decoder side  (drives phase_err, err_valid)
//     slave   filter side   (drives err_ready)
// ---------------------------------------------------------------------------
interface tdc_phase_error_decoder_if #(
    parameter int ERR_W = 10
) ();

    logic signed [ERR_W-1:0] phase_err;
    logic                    err_valid;
    logic                    err_ready;

    modport master (
        output phase_err,
        output err_valid,
        input  err_ready
    );

    modport slave (
        input  phase_err,
        input  err_valid,
        output err_ready
    );

endinterface

// File: rtl/tdc_therm_popcount.sv
// ---------------------------------------------------------------------------
// tdc_therm_popcount
//   Combinational count of ones in an active-high thermometer word. Counting
//   every set bit (instead of locating the 1->0 boundary) keeps the result
//   sensible when metastability leaves bubbles in the code.
//   Ports:
//     therm_i  [N-1:0]   active-high thermometer (already inverted trip_b)
//     count_o  [CW-1:0]  number of set bits, 0..N
// ---------------------------------------------------------------------------
module tdc_therm_popcount
    import tdc_pkg::*;
#(
    parameter int N  = FINE_STEPS,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  therm_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + CW'(therm_i[i]);
        end
    end

endmodule

// File: rtl/tdc_phase_error_decoder.sv
// ---------------------------------------------------------------------------
// tdc_phase_error_decoder
//   Turns one PFD/TDC measurement per reference edge into a signed phase
//   error word and hands it to the loop filter over a valid/ready channel.
//
//   Ports:
//     ref_clk         reference clock, all logic on the rising edge
//     reset           asynchronous active-low reset
//     enable_PFD_TDC  block enable; low flushes the FSM to IDLE
//     fine_done_pre   measurement-complete level, asynchronous to ref_clk
//     early           1 = reference leads DCO (positive error)
//     counter_rise    coarse count of DCO rising edges
//     counter_fall    coarse count of DCO falling edges
//     trip_b          active-low TDC thermometer (all ones = nothing tripped)
//     err_if          phase_err / err_valid / err_ready channel (master)
//     cnt_mismatch    sticky: rise/fall counts differed by more than one
//     overrun         sticky: a measurement was dropped, output occupied
//     dbg_state_o     current FSM state
//
//   Build option PHERR_AVG_EN: when defined, measurements are averaged in
//   pairs, (s0 + s1) >>> 1, and one word is produced per two measurements.
//
//   Timing: a rise of fine_done_pre is seen by the FSM on the third ref_clk
//   edge after it (two synchroniser flops plus the edge-detect history flop
//   update on that same edge); err_valid rises two edges later.
// ---------------------------------------------------------------------------
module tdc_phase_error_decoder
    import tdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic                      ref_clk,
    input  logic                      reset,
    input  logic                      enable_PFD_TDC,
    input  logic                      fine_done_pre,
    input  logic                      early,
    input  logic [CNT_W-1:0]          counter_rise,
    input  logic [CNT_W-1:0]          counter_fall,
    input  logic [FINE_STEPS-1:0]     trip_b,
    tdc_phase_error_decoder_if.master err_if,
    output logic                      cnt_mismatch,
    output logic                      overrun,
    output tdc_state_e                dbg_state_o
);

    localparam int FINE_W  = $clog2(FINE_STEPS + 1);
    // counter_rise * FINE_STEPS + FINE_STEPS, with one bit of headroom
    localparam int MAG_W   = CNT_W + FINE_W + 1;
    localparam int ERR_LIM = err_sat_max(ERR_W);

    // -----------------------------------------------------------------------
    // Synchroniser and rising-edge detect. sync3_q is the previous value of
    // the synchronised level; it keeps running while disabled so that
    // re-enabling with fine_done_pre already high does not look like a rise.
    // -----------------------------------------------------------------------
    logic sync1_q, sync2_q, sync3_q;
    logic detect;

    assign detect = sync2_q & ~sync3_q;

    // -----------------------------------------------------------------------
    // State and captured measurement
    // -----------------------------------------------------------------------
    tdc_state_e              state_q, state_d;
    logic                    cap_early_q, cap_early_d;
    logic [CNT_W-1:0]        cap_rise_q, cap_rise_d;
    logic [CNT_W-1:0]        cap_fall_q, cap_fall_d;
    logic [FINE_STEPS-1:0]   therm_q, therm_d;
    logic signed [ERR_W-1:0] phase_err_q, phase_err_d;
    logic                    mismatch_q, mismatch_d;
    logic                    overrun_q, overrun_d;

`ifdef PHERR_AVG_EN
    logic signed [ERR_W-1:0] acc_q, acc_d;
    logic                    parity_q, parity_d;
    logic signed [ERR_W:0]   pair_sum;
    logic signed [ERR_W-1:0] pair_avg;
`endif

    // -----------------------------------------------------------------------
    // Arithmetic on the captured measurement (used in CALC)
    // -----------------------------------------------------------------------
    logic [FINE_W-1:0]       fine;
    logic [MAG_W-1:0]        mag;
    logic signed [31:0]      mag_int;
    logic signed [31:0]      sat_int;
    logic signed [31:0]      sample_int;
    logic signed [ERR_W-1:0] sample;
    logic [CNT_W-1:0]        cnt_diff;
    logic                    cnt_bad;

    tdc_therm_popcount #(
        .N  (FINE_STEPS),
        .CW (FINE_W)
    ) u_popcount (
        .therm_i (therm_q),
        .count_o (fine)
    );

    always_comb begin
        mag        = MAG_W'(cap_rise_q) * MAG_W'(FINE_STEPS) + MAG_W'(fine);
        mag_int    = 32'(mag);
        // Clamp the magnitude first; the limits are symmetric so the sign
        // can be applied afterwards. mag == 0 naturally yields 0.
        sat_int    = (mag_int > ERR_LIM) ? ERR_LIM : mag_int;
        sample_int = cap_early_q ? sat_int : -sat_int;
        sample     = sample_int[ERR_W-1:0];
    end

    always_comb begin
        cnt_diff = (cap_rise_q >= cap_fall_q) ? (cap_rise_q - cap_fall_q)
                                              : (cap_fall_q - cap_rise_q);
        cnt_bad  = (cnt_diff > CNT_W'(1));
    end

`ifdef PHERR_AVG_EN
    // Dropping bit 0 of the sign-extended sum is an arithmetic shift right,
    // i.e. the average rounds toward minus infinity.
    always_comb begin
        pair_sum = {acc_q[ERR_W-1], acc_q} + {sample[ERR_W-1], sample};
        pair_avg = pair_sum[ERR_W:1];
    end
`endif

    // -----------------------------------------------------------------------
    // FSM next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cap_early_d = cap_early_q;
        cap_rise_d  = cap_rise_q;
        cap_fall_d  = cap_fall_q;
        therm_d     = therm_q;
        phase_err_d = phase_err_q;
        mismatch_d  = mismatch_q;
        overrun_d   = overrun_q;
`ifdef PHERR_AVG_EN
        acc_d       = acc_q;
        parity_d    = parity_q;
`endif

        if (!enable_PFD_TDC) begin
            // Flush: the pending word (if any) is withdrawn. Sticky flags
            // survive; a half-collected averaging pair does not.
            state_d = IDLE;
`ifdef PHERR_AVG_EN
            parity_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (detect) begin
                        state_d = CAPT;
                    end
                end

                CAPT: begin
                    cap_early_d = early;
                    cap_rise_d  = counter_rise;
                    cap_fall_d  = counter_fall;
                    therm_d     = ~trip_b;
                    state_d     = CALC;
                    if (detect) begin
                        overrun_d = 1'b1;
                    end
                end

                CALC: begin
                    if (cnt_bad) begin
                        mismatch_d = 1'b1;
                    end
                    if (detect) begin
                        overrun_d = 1'b1;
                    end
`ifdef PHERR_AVG_EN
                    if (!parity_q) begin
                        // First of a pair: remember it, emit nothing.
                        acc_d    = sample;
                        parity_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        phase_err_d = pair_avg;
                        parity_d    = 1'b0;
                        state_d     = OUT;
                    end
`else
                    phase_err_d = sample;
                    state_d     = OUT;
`endif
                end

                OUT: begin
                    if (err_if.err_ready) begin
                        // The slot frees on this edge, so a new measurement
                        // arriving now can be taken instead of dropped.
                        state_d = detect ? CAPT : IDLE;
                    end else if (detect) begin
                        overrun_d = 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            state_q     <= IDLE;
            cap_early_q <= 1'b0;
            cap_rise_q  <= '0;
            cap_fall_q  <= '0;
            therm_q     <= '0;
            phase_err_q <= '0;
            mismatch_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PHERR_AVG_EN
            acc_q       <= '0;
            parity_q    <= 1'b0;
`endif
        end else begin
            sync1_q     <= fine_done_pre;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            state_q     <= state_d;
            cap_early_q <= cap_early_d;
            cap_rise_q  <= cap_rise_d;
            cap_fall_q  <= cap_fall_d;
            therm_q     <= therm_d;
            phase_err_q <= phase_err_d;
            mismatch_q  <= mismatch_d;
            overrun_q   <= overrun_d;
`ifdef PHERR_AVG_EN
            acc_q       <= acc_d;
            parity_q    <= parity_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign err_if.err_valid = (state_q == OUT);
    assign err_if.phase_err = phase_err_q;
    assign cnt_mismatch     = mismatch_q;
    assign overrun          = overrun_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_tdc_phase_error_decoder.sv
// ---------------------------------------------------------------------------
// tb_tdc_phase_error_decoder
//   Directed bench for tdc_phase_error_decoder. Two instances share every
//   input: one with the default 10-bit phase error and one with an 8-bit
//   phase error to exercise saturation. Transferred words of the 10-bit
//   instance are checked against an expected queue; everything else is
//   compared directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_tdc_phase_error_decoder;
    import tdc_pkg::*;

    // ---------------- clock / reset ----------------
    logic ref_clk;
    logic reset;

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // ---------------- DUT inputs ----------------
    logic       enable_PFD_TDC;
    logic       fine_done_pre;
    logic       early;
    logic [4:0] counter_rise;
    logic [4:0] counter_fall;
    logic [7:0] trip_b;
    logic       err_ready;

    logic       mism10, ovr10, mism8, ovr8;
    tdc_state_e dbg10, dbg8;

    tdc_phase_error_decoder_if #(.ERR_W(10)) if10 ();
    tdc_phase_error_decoder_if #(.ERR_W(8))  if8 ();

    assign if10.err_ready = err_ready;
    assign if8.err_ready  = err_ready;

    tdc_phase_error_decoder #(.CNT_W(5), .ERR_W(10)) dut (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .enable_PFD_TDC (enable_PFD_TDC),
        .fine_done_pre  (fine_done_pre),
        .early          (early),
        .counter_rise   (counter_rise),
        .counter_fall   (counter_fall),
        .trip_b         (trip_b),
        .err_if         (if10),
        .cnt_mismatch   (mism10),
        .overrun        (ovr10),
        .dbg_state_o    (dbg10)
    );

    tdc_phase_error_decoder #(.CNT_W(5), .ERR_W(8)) dut8 (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .enable_PFD_TDC (enable_PFD_TDC),
        .fine_done_pre  (fine_done_pre),
        .early          (early),
        .counter_rise   (counter_rise),
        .counter_fall   (counter_fall),
        .trip_b         (trip_b),
        .err_if         (if8),
        .cnt_mismatch   (mism8),
        .overrun        (ovr8),
        .dbg_state_o    (dbg8)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_xfer   = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Transfers happen on the next rising edge; sample mid-cycle.
    always @(negedge ref_clk) begin
        if (reset && if10.err_valid && if10.err_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("xfer_queue", exp_q.size(), 1);
            end else begin
                check("xfer_word", $signed(if10.phase_err), $signed(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic set_meas(input logic e, input logic [4:0] r, input logic [4:0] f,
                            input logic [7:0] t);
        early        = e;
        counter_rise = r;
        counter_fall = f;
        trip_b       = t;
    endtask

    // One measurement with err_ready high. out_exp says whether a word is
    // expected to come out of this measurement.
    task automatic do_meas(input logic e, input logic [4:0] r, input logic [4:0] f,
                           input logic [7:0] t, input logic out_exp,
                           input int exp10, input int exp8, input string tag);
        set_meas(e, r, f, t);
        if (out_exp) exp_q.push_back(10'(exp10));
        fine_done_pre = 1'b1;
        tick(4);
        check({tag, "_not_yet"}, int'(if10.err_valid), 0);
        tick(1);
        check({tag, "_valid"}, int'(if10.err_valid), int'(out_exp));
        if (out_exp) check({tag, "_w8"}, $signed(if8.phase_err), exp8);
        fine_done_pre = 1'b0;
        tick(4);
    endtask

    // ---------------- stimulus ----------------
    int xfer_before;

    initial begin
        reset          = 1'b0;
        enable_PFD_TDC = 1'b1;
        fine_done_pre  = 1'b0;
        err_ready      = 1'b0;
        set_meas(1'b0, 5'd0, 5'd0, 8'hFF);
        tick(3);
        reset = 1'b1;
        tick(2);

        // Reset state
        check("rst_valid",    int'(if10.err_valid), 0);
        check("rst_phase",    $signed(if10.phase_err), 0);
        check("rst_mismatch", int'(mism10), 0);
        check("rst_overrun",  int'(ovr10), 0);
        check("rst_state",    int'(dbg10), int'(IDLE));

        err_ready = 1'b1;

`ifdef PHERR_AVG_EN
        // Pair +28, +9 -> (37) >>> 1 = 18
        do_meas(1'b1, 5'd3, 5'd3, 8'b11110000, 1'b0, 0, 0, "avg_a0");
        do_meas(1'b1, 5'd1, 5'd1, 8'b11111110, 1'b1, 18, 18, "avg_a1");
        // First of a pair, then enable low: the pair restarts
        do_meas(1'b1, 5'd3, 5'd3, 8'b11110000, 1'b0, 0, 0, "avg_b0");
        enable_PFD_TDC = 1'b0;
        tick(2);
        enable_PFD_TDC = 1'b1;
        tick(2);
        do_meas(1'b1, 5'd1, 5'd1, 8'b11111110, 1'b0, 0, 0, "avg_restart");
        // +9 with -3 -> 6 >>> 1 = 3
        do_meas(1'b0, 5'd0, 5'd0, 8'b11111000, 1'b1, 3, 3, "avg_c");
        // -3 with 0 -> -3 >>> 1 = -2 (toward minus infinity)
        do_meas(1'b0, 5'd0, 5'd0, 8'b11111000, 1'b0, 0, 0, "avg_d0");
        do_meas(1'b1, 5'd0, 5'd0, 8'hFF,       1'b1, -2, -2, "avg_floor");
        check("avg_overrun", int'(ovr10), 0);
`else
        // +28 with latency: detect on edge 3, valid on edge 5
        set_meas(1'b1, 5'd3, 5'd3, 8'b11110000);
        exp_q.push_back(10'd28);
        fine_done_pre = 1'b1;
        tick(3);
        check("lat_capt", int'(dbg10), int'(CAPT));
        tick(1);
        check("lat_not_yet", int'(if10.err_valid), 0);
        tick(1);
        check("lat_valid", int'(if10.err_valid), 1);
        check("lat_phase", $signed(if10.phase_err), 28);
        check("lat_w8", $signed(if8.phase_err), 28);
        tick(1);
        check("lat_drop", int'(if10.err_valid), 0);
        fine_done_pre = 1'b0;
        tick(3);

        // 31*8 + 8 = 256 -> -256; 8-bit instance saturates at -127
        do_meas(1'b0, 5'd31, 5'd31, 8'h00,       1'b1, -256, -127, "sat");
        // bubbled thermometer: four zeros -> fine = 4
        do_meas(1'b1, 5'd0,  5'd0,  8'b10101010, 1'b1, 4, 4, "bubble");
        do_meas(1'b1, 5'd0,  5'd0,  8'hFF,       1'b1, 0, 0, "zero");
        // counts differing by exactly one are not a mismatch
        do_meas(1'b0, 5'd5,  5'd4,  8'b11111110, 1'b1, -41, -41, "diff1");
        check("diff1_mismatch", int'(mism10), 0);

        // Back-to-back: second pulse arrives while OUT with ready high
        set_meas(1'b1, 5'd2, 5'd2, 8'b11110000);
        exp_q.push_back(10'd20);
        fine_done_pre = 1'b1;
        tick(1);
        fine_done_pre = 1'b0;
        tick(2);
        fine_done_pre = 1'b1;
        tick(1);
        set_meas(1'b0, 5'd1, 5'd1, 8'hFF);
        exp_q.push_back(-10'sd8);
        tick(1);
        check("b2b_first_valid", int'(if10.err_valid), 1);
        tick(1);
        check("b2b_recapt", int'(dbg10), int'(CAPT));
        tick(2);
        check("b2b_second_valid", int'(if10.err_valid), 1);
        fine_done_pre = 1'b0;
        tick(3);
        check("b2b_no_overrun", int'(ovr10), 0);

        // Overrun: ready low, second measurement is dropped
        err_ready = 1'b0;
        set_meas(1'b1, 5'd1, 5'd1, 8'b11111100);
        exp_q.push_back(10'd10);
        fine_done_pre = 1'b1;
        tick(5);
        check("ovr_first_valid", int'(if10.err_valid), 1);
        check("ovr_first_phase", $signed(if10.phase_err), 10);
        fine_done_pre = 1'b0;
        tick(3);
        set_meas(1'b0, 5'd7, 5'd7, 8'h00);
        fine_done_pre = 1'b1;
        tick(4);
        check("ovr_set", int'(ovr10), 1);
        check("ovr_held_valid", int'(if10.err_valid), 1);
        check("ovr_held_phase", $signed(if10.phase_err), 10);
        fine_done_pre = 1'b0;
        tick(3);
        xfer_before = n_xfer;
        err_ready = 1'b1;
        tick(6);
        check("ovr_one_xfer", n_xfer - xfer_before, 1);
        check("ovr_idle", int'(if10.err_valid), 0);

        // Count mismatch, sticky across a clean sample
        do_meas(1'b1, 5'd4, 5'd7, 8'hFF, 1'b1, 32, 32, "mism");
        check("mism_set", int'(mism10), 1);
        do_meas(1'b0, 5'd2, 5'd2, 8'hFF, 1'b1, -16, -16, "clean");
        check("mism_sticky", int'(mism10), 1);

        // Enable low drops a pending word without a transfer
        err_ready = 1'b0;
        set_meas(1'b1, 5'd0, 5'd0, 8'b11111110);
        fine_done_pre = 1'b1;
        tick(5);
        check("en_valid", int'(if10.err_valid), 1);
        check("en_phase", $signed(if10.phase_err), 1);
        enable_PFD_TDC = 1'b0;
        tick(1);
        check("en_dropped", int'(if10.err_valid), 0);
        check("en_state", int'(dbg10), int'(IDLE));
        enable_PFD_TDC = 1'b1;
        tick(5);
        check("en_no_false_edge", int'(if10.err_valid), 0);
        check("en_mism_kept", int'(mism10), 1);
        check("en_ovr_kept", int'(ovr10), 1);
        fine_done_pre = 1'b0;
        err_ready = 1'b1;
        tick(3);

        // Reset in the middle of a measurement
        set_meas(1'b1, 5'd3, 5'd3, 8'h00);
        fine_done_pre = 1'b1;
        tick(4);
        check("mid_calc", int'(dbg10), int'(CALC));
        reset = 1'b0;
        fine_done_pre = 1'b0;
        #1;
        check("mid_state", int'(dbg10), int'(IDLE));
        check("mid_valid", int'(if10.err_valid), 0);
        check("mid_mism", int'(mism10), 0);
        check("mid_ovr", int'(ovr10), 0);
        check("mid_phase", $signed(if10.phase_err), 0);
        tick(2);
        reset = 1'b1;
        tick(6);
        check("mid_no_word", int'(if10.err_valid), 0);
`endif

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
